// File: rtl/four_bit_divider_if.sv
// Handshake/operand bundle for four_bit_divider: the master drives start/A/B,
// and the divider slave returns Q/R and the status flags.
interface four_bit_divider_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       dz;

  modport master (output start, A, B, input Q, R, busy, done, dz);
  modport slave  (input start, A, B, output Q, R, busy, done, dz);
endinterface

// File: rtl/four_bit_divider.sv
// 4-bit restoring divider: IDLE/RUN/DONE FSM, one quotient bit per cycle, MSB first.
// Optional macro DIV_ZERO_DETECT_EN: early divide-by-zero exit with dz flag.
module four_bit_divider (
  input logic              clk,
  input logic              reset,
  four_bit_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] dvd, dvs, rem, quo;
  logic [3:0] q_reg, r_reg;
  logic [1:0] cnt;
  logic       accept, div_zero;
  logic [4:0] shifted, diff;
  logic [3:0] quo_next, rem_next;

  assign accept = bus.start && (state != RUN);

`ifdef DIV_ZERO_DETECT_EN
  assign div_zero = (bus.B == '0);
`else
  assign div_zero = 1'b0;
`endif

  // 5-bit trial difference: sign bit clear means the divisor fit
  always_comb begin
    shifted  = {rem, dvd[3]};
    diff     = shifted - {1'b0, dvs};
    quo_next = {quo[2:0], ~diff[4]};
    rem_next = diff[4] ? shifted[3:0] : diff[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = div_zero ? DONE : RUN;
        else        state_next = IDLE;
      end
      RUN:     if (cnt == 2'd3) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      q_reg <= '0;
      r_reg <= '0;
    end else if (accept) begin
      dvd <= bus.A;
      dvs <= bus.B;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      if (div_zero) begin
        q_reg <= '1;
        r_reg <= bus.A;
      end
    end else if (state == RUN) begin
      dvd <= {dvd[2:0], 1'b0};
      rem <= rem_next;
      quo <= quo_next;
      cnt <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        q_reg <= quo_next;
        r_reg <= rem_next;
      end
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_reg;

  always_ff @(posedge clk) begin
    if (reset)
      dz_reg <= 1'b0;
    else if (accept && div_zero)
      dz_reg <= 1'b1;
    else if (state == RUN && cnt == 2'd3)
      dz_reg <= 1'b0;
  end

  assign bus.dz = dz_reg;
`else
  assign bus.dz = 1'b0;
`endif

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_four_bit_divider.sv
// Self-checking bench for four_bit_divider: directed scenarios, exhaustive sweep
// and random operations against an arithmetic reference model.
module tb_four_bit_divider;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  four_bit_divider_if dif ();

  four_bit_divider dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  int errors = 0;
  int checks = 0;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  // Reference model: plain integer arithmetic, B==0 yields all-ones / dividend
  function automatic logic [3:0] ref_q(input logic [3:0] a, input logic [3:0] b);
    if (b == 4'd0) return 4'hF;
    return 4'(int'(a) / int'(b));
  endfunction

  function automatic logic [3:0] ref_r(input logic [3:0] a, input logic [3:0] b);
    if (b == 4'd0) return a;
    return 4'(int'(a) % int'(b));
  endfunction

  function automatic int ref_lat(input logic [3:0] b);
    return (DZ_EN && b == 4'd0) ? 1 : 5;
  endfunction

  function automatic int ref_busy(input logic [3:0] b);
    return (DZ_EN && b == 4'd0) ? 0 : 4;
  endfunction

  function automatic logic ref_dz(input logic [3:0] b);
    return DZ_EN && (b == 4'd0);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; returns in the cycle after the accepting edge
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    dif.A     = a;
    dif.B     = b;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
  endtask

  // Cycles from accepting edge to the done cycle (bounded), plus busy cycles seen
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (dif.done !== 1'b1 && lat < 20) begin
      if (dif.busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    dif.start = 1'b1;
    dif.A     = 4'd11;
    dif.B     = 4'd2;
    tick();
    tick();
    checks++;
    if ({dif.Q, dif.R} !== 8'h00) begin
      errors++;
      $display("FAIL reset_qr: got Q=%0d R=%0d expected Q=0 R=0", dif.Q, dif.R);
    end
    checks++;
    if ({dif.busy, dif.done, dif.dz} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy=%b done=%b dz=%b expected 000", dif.busy, dif.done, dif.dz);
    end
    dif.start = 1'b0;
    reset     = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int lat, busy_n;
    launch(4'd13, 4'd3);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 5 || busy_n !== 4) begin
      errors++;
      $display("FAIL basic_timing: got lat=%0d busy=%0d expected lat=5 busy=4", lat, busy_n);
    end
    checks++;
    if (dif.Q !== 4'd4 || dif.R !== 4'd1 || dif.dz !== 1'b0 || dif.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got Q=%0d R=%0d dz=%b busy=%b expected Q=4 R=1 dz=0 busy=0",
               dif.Q, dif.R, dif.dz, dif.busy);
    end
    tick();
    checks++;
    if (dif.done !== 1'b0 || dif.Q !== 4'd4 || dif.R !== 4'd1) begin
      errors++;
      $display("FAIL basic_hold: got done=%b Q=%0d R=%0d expected done=0 Q=4 R=1", dif.done, dif.Q, dif.R);
    end
  endtask

  task automatic test_back_to_back;
    int lat, busy_n;
    launch(4'd2, 4'd5);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 5 || dif.Q !== 4'd0 || dif.R !== 4'd2) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d Q=%0d R=%0d expected lat=5 Q=0 R=2", lat, dif.Q, dif.R);
    end
    launch(4'd15, 4'd1);
    checks++;
    if (dif.busy !== 1'b1 || dif.Q !== 4'd0 || dif.R !== 4'd2) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b Q=%0d R=%0d expected busy=1 Q=0 R=2", dif.busy, dif.Q, dif.R);
    end
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 5 || dif.Q !== 4'd15 || dif.R !== 4'd0) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d Q=%0d R=%0d expected lat=5 Q=15 R=0", lat, dif.Q, dif.R);
    end
    tick();
  endtask

  task automatic test_ignore_start;
    int lat, busy_n;
    launch(4'd13, 4'd3);
    tick();
    dif.A     = 4'd9;
    dif.B     = 4'd2;
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    wait_done(lat, busy_n);
    checks++;
    if (lat + 2 !== 5 || dif.Q !== 4'd4 || dif.R !== 4'd1) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d Q=%0d R=%0d expected lat=5 Q=4 R=1", lat + 2, dif.Q, dif.R);
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    int lat, busy_n, pulses;
    launch(4'd14, 4'd4);
    wait_done(lat, busy_n);
    tick();
    launch(4'd13, 4'd3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (dif.busy !== 1'b0 || dif.Q !== 4'd0 || dif.R !== 4'd0) begin
      errors++;
      $display("FAIL reset_run: got busy=%b Q=%0d R=%0d expected busy=0 Q=0 R=0", dif.busy, dif.Q, dif.R);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (dif.done === 1'b1 || dif.busy === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0 || dif.Q !== 4'd0 || dif.R !== 4'd0) begin
      errors++;
      $display("FAIL reset_abandon: got activity=%0d Q=%0d R=%0d expected activity=0 Q=0 R=0",
               pulses, dif.Q, dif.R);
    end
  endtask

  task automatic test_div_zero;
    int lat, busy_n;
    launch(4'd7, 4'd0);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== ref_lat(4'd0) || busy_n !== ref_busy(4'd0)) begin
      errors++;
      $display("FAIL dz_timing: got lat=%0d busy=%0d expected lat=%0d busy=%0d",
               lat, busy_n, ref_lat(4'd0), ref_busy(4'd0));
    end
    checks++;
    if (dif.Q !== 4'd15 || dif.R !== 4'd7 || dif.dz !== ref_dz(4'd0)) begin
      errors++;
      $display("FAIL dz_result: got Q=%0d R=%0d dz=%b expected Q=15 R=7 dz=%b",
               dif.Q, dif.R, dif.dz, ref_dz(4'd0));
    end
    tick();
    launch(4'd9, 4'd3);
    checks++;
    if (dif.dz !== ref_dz(4'd0)) begin
      errors++;
      $display("FAIL dz_hold: got dz=%b expected %b", dif.dz, ref_dz(4'd0));
    end
    wait_done(lat, busy_n);
    checks++;
    if (dif.dz !== 1'b0 || dif.Q !== 4'd3 || dif.R !== 4'd0) begin
      errors++;
      $display("FAIL dz_clear: got dz=%b Q=%0d R=%0d expected dz=0 Q=3 R=0", dif.dz, dif.Q, dif.R);
    end
    tick();
  endtask

  task automatic test_sweep;
    int lat, busy_n;
    for (int unsigned a = 0; a < 16; a++) begin
      for (int unsigned b = 1; b < 16; b++) begin
        launch(4'(a), 4'(b));
        wait_done(lat, busy_n);
        checks++;
        if (lat !== 5 || dif.Q !== ref_q(4'(a), 4'(b)) || dif.R !== ref_r(4'(a), 4'(b))) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: got lat=%0d Q=%0d R=%0d expected lat=5 Q=%0d R=%0d",
                   a, b, lat, dif.Q, dif.R, ref_q(4'(a), 4'(b)), ref_r(4'(a), 4'(b)));
        end
        if ((a + b) % 3 != 0) tick();
      end
    end
    tick();
  endtask

  task automatic test_random;
    int lat, busy_n;
    logic [3:0] a, b;
    for (int i = 0; i < 60; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      launch(a, b);
      wait_done(lat, busy_n);
      checks++;
      if (lat !== ref_lat(b) || busy_n !== ref_busy(b) || dif.Q !== ref_q(a, b) ||
          dif.R !== ref_r(a, b) || dif.dz !== ref_dz(b)) begin
        errors++;
        $display("FAIL random_%0d (A=%0d B=%0d): got lat=%0d busy=%0d Q=%0d R=%0d dz=%b expected lat=%0d busy=%0d Q=%0d R=%0d dz=%b",
                 i, a, b, lat, busy_n, dif.Q, dif.R, dif.dz,
                 ref_lat(b), ref_busy(b), ref_q(a, b), ref_r(a, b), ref_dz(b));
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    dif.start = 1'b0;
    dif.A     = '0;
    dif.B     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_div_zero();
    test_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
